// File: rtl/blink_lcd_fetch_pkg.sv
// Shared encodings and address helpers for the blink LCD display fetch path.
package blink_lcd_fetch_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_ACC, ST_PUSH} state_e;
  typedef enum logic [1:0] {STEP_LO, STEP_HI, STEP_FONT} step_e;

  localparam int ATTR_HRS   = 5;
  localparam int ATTR_CODE8 = 0;
  localparam int ATTR_CODE9 = 1;

  localparam logic [8:0] LORES0_BASE = 9'h1C0;
  localparam logic [9:0] HIRES1_BASE = 10'd768;

  localparam int CELL_W = 18;

  // code is {hi[1:0], lo}; lores only looks at the low 9 bits
  function automatic logic [21:0] font_addr(input logic        hrs,
                                            input logic [9:0]  code,
                                            input logic [2:0]  pl,
                                            input logic [12:0] pb0,
                                            input logic [9:0]  pb1,
                                            input logic [8:0]  pb2,
                                            input logic [10:0] pb3);
    logic [21:0] a;
    if (hrs) begin
      if (code >= HIRES1_BASE) a = {pb3, code[7:0], pl};
      else                     a = {pb2, code, pl};
    end else begin
      if (code[8:0] >= LORES0_BASE) a = {pb0, code[5:0], pl};
      else                          a = {pb1, code[8:0], pl};
    end
    font_addr = a;
  endfunction

endpackage

// File: rtl/blink_lcd_fetch_fifo2.sv
// Two-entry valid/ready FIFO between the fetch scheduler and the LCD serializer.
module lcd_fifo2 #(
  parameter int W = 18
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q, rd_q;
  logic [1:0]   cnt_q;
  logic         do_push, do_pop;

  assign valid_o = (cnt_q != 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign do_pop  = valid_o & ready_i;
  // a full FIFO can still accept when its head leaves in the same cycle
  assign do_push = push_i & (!full_o | do_pop);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/blink_lcd_fetch.sv
// Display fetch scheduler: steals ma-bus cycles from the Z80 to walk screen
// cells (lo, hi, font) and queue {font, attribute} cells for the serializer.
module blink_lcd_fetch
  import blink_lcd_fetch_pkg::*;
#(
  parameter int COLS       = 106,
  parameter int LINES      = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic        mck,
  input  logic        rin_n,
  input  logic        lcd_on,
  input  logic        frame_tick,
  input  logic [12:0] pb0,
  input  logic [9:0]  pb1,
  input  logic [8:0]  pb2,
  input  logic [10:0] pb3,
  input  logic [10:0] sbr,
  input  logic        cpu_req,
  output logic        cpu_wait_n,
  output logic        disp_gnt,
  output logic [21:0] disp_ma,
  output logic        disp_roe_n,
  input  logic [7:0]  mem_di,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_font,
  output logic [7:0]  pix_attr,
  output logic        pix_sol,
  output logic        pix_sof,
  output logic        busy
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int SW    = $clog2(STARVE_MAX + 1);

  state_e             state_q, state_d;
  step_e              step_q, step_d;
  logic [6:0]         col_q, col_d;
  logic [5:0]         line_q, line_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [SW-1:0]      starve_cnt_q, starve_cnt_d, starve_inc;
  logic               starve_q, starve_d;
  logic [7:0]         lo_q, lo_d, hi_q, hi_d, font_q, font_d;
  logic [10:0]        sbr_s_q, sbr_s_d;
  logic [12:0]        pb0_s_q, pb0_s_d;
  logic [9:0]         pb1_s_q, pb1_s_d;
  logic [8:0]         pb2_s_q, pb2_s_d;
  logic [10:0]        pb3_s_q, pb3_s_d;
  logic               push, flush, fifo_full;
  logic               sol;
  logic [21:0]        acc_addr;
  logic [CELL_W-1:0]  cell_in, cell_out;

  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      state_q      <= ST_IDLE;
      step_q       <= STEP_LO;
      col_q        <= '0;
      line_q       <= '0;
      lat_q        <= '0;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
      lo_q         <= '0;
      hi_q         <= '0;
      font_q       <= '0;
      sbr_s_q      <= '0;
      pb0_s_q      <= '0;
      pb1_s_q      <= '0;
      pb2_s_q      <= '0;
      pb3_s_q      <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      col_q        <= col_d;
      line_q       <= line_d;
      lat_q        <= lat_d;
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      font_q       <= font_d;
      sbr_s_q      <= sbr_s_d;
      pb0_s_q      <= pb0_s_d;
      pb1_s_q      <= pb1_s_d;
      pb2_s_q      <= pb2_s_d;
      pb3_s_q      <= pb3_s_d;
    end
  end

  assign starve_inc = starve_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    col_d        = col_q;
    line_d       = line_q;
    lat_d        = lat_q;
    starve_cnt_d = starve_cnt_q;
    starve_d     = starve_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    font_d       = font_q;
    sbr_s_d      = sbr_s_q;
    pb0_s_d      = pb0_s_q;
    pb1_s_d      = pb1_s_q;
    pb2_s_d      = pb2_s_q;
    pb3_s_d      = pb3_s_q;
    push         = 1'b0;
    flush        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick && lcd_on) begin
          state_d      = ST_ARB;
          step_d       = STEP_LO;
          col_d        = '0;
          line_d       = '0;
          starve_cnt_d = '0;
          starve_d     = 1'b0;
          sbr_s_d      = sbr;
          pb0_s_d      = pb0;
          pb1_s_d      = pb1;
          pb2_s_d      = pb2;
          pb3_s_d      = pb3;
        end
      end
      ST_ARB: begin
        if (!lcd_on) begin
          state_d = ST_IDLE;
          flush   = 1'b1;
        end else begin
          if (cpu_req && !starve_q) begin
            starve_cnt_d = starve_inc;
            if (starve_inc == SW'(STARVE_MAX)) starve_d = 1'b1;
          end
          // LO only starts with a free slot, so PUSH never meets a full FIFO
          if ((step_q != STEP_LO || !fifo_full) && (!cpu_req || starve_q)) begin
            state_d = ST_ACC;
            lat_d   = LAT_W'(MEM_LAT - 1);
          end
        end
      end
      ST_ACC: begin
        if (lat_q == '0) begin
          case (step_q)
            STEP_LO: lo_d   = mem_di;
            STEP_HI: hi_d   = mem_di;
            default: font_d = mem_di;
          endcase
          starve_cnt_d = '0;
          starve_d     = 1'b0;
          if (!lcd_on) begin
            state_d = ST_IDLE;
            flush   = 1'b1;
          end else if (step_q == STEP_FONT) begin
            state_d = ST_PUSH;
          end else begin
            state_d = ST_ARB;
            step_d  = (step_q == STEP_LO) ? STEP_HI : STEP_FONT;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      ST_PUSH: begin
        step_d = STEP_LO;
        if (!lcd_on) begin
          state_d = ST_IDLE;
          flush   = 1'b1;
        end else begin
          push    = 1'b1;
          state_d = ST_ARB;
          if (col_q == 7'(COLS - 1)) begin
            col_d = '0;
            if (line_q == 6'(LINES - 1)) state_d = ST_IDLE;
            else                         line_d  = line_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_addr = {sbr_s_q, line_q[5:3], col_q, step_q == STEP_HI};
    if (step_q == STEP_FONT)
      acc_addr = font_addr(hi_q[ATTR_HRS], {hi_q[ATTR_CODE9:ATTR_CODE8], lo_q},
                           line_q[2:0], pb0_s_q, pb1_s_q, pb2_s_q, pb3_s_q);
  end

  assign disp_gnt   = (state_q == ST_ACC);
  assign disp_roe_n = !disp_gnt;
  assign disp_ma    = disp_gnt ? acc_addr : '0;
  assign cpu_wait_n = !(disp_gnt && (cpu_req || starve_q));
  assign busy       = (state_q != ST_IDLE);

  assign sol     = (col_q == 7'd0);
  assign cell_in = {sol && (line_q == 6'd0), sol, hi_q, font_q};

  lcd_fifo2 #(.W(CELL_W)) u_fifo (
    .clk_i   (mck),
    .rst_n_i (rin_n),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (cell_in),
    .full_o  (fifo_full),
    .valid_o (pix_valid),
    .ready_i (pix_ready),
    .data_o  (cell_out)
  );

  assign {pix_sof, pix_sol, pix_attr, pix_font} = cell_out;

endmodule

// File: tb/tb_blink_lcd_fetch.sv
// Self-checking bench for blink_lcd_fetch: hashed memory model, address and
// cell scoreboard derived arithmetically from the addressing rules.
module tb_blink_lcd_fetch;

  localparam int COLS       = 16;
  localparam int LINES      = 64;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 8;

  logic        mck = 1'b0;
  logic        rin_n, lcd_on, frame_tick, cpu_req, pix_ready;
  logic [12:0] pb0;
  logic [9:0]  pb1;
  logic [8:0]  pb2;
  logic [10:0] pb3, sbr;
  logic [7:0]  mem_di;
  logic        cpu_wait_n, disp_gnt, disp_roe_n, pix_valid, pix_sol, pix_sof, busy;
  logic [21:0] disp_ma;
  logic [7:0]  pix_font, pix_attr;

  int checks = 0;
  int errors = 0;

  always #5 mck = ~mck;

  blink_lcd_fetch #(.COLS(COLS), .LINES(LINES), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .mck(mck), .rin_n(rin_n), .lcd_on(lcd_on), .frame_tick(frame_tick),
    .pb0(pb0), .pb1(pb1), .pb2(pb2), .pb3(pb3), .sbr(sbr), .cpu_req(cpu_req),
    .cpu_wait_n(cpu_wait_n), .disp_gnt(disp_gnt), .disp_ma(disp_ma), .disp_roe_n(disp_roe_n),
    .mem_di(mem_di), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_font(pix_font),
    .pix_attr(pix_attr), .pix_sol(pix_sol), .pix_sof(pix_sof), .busy(busy)
  );

  // memory model: hashed contents plus a few pinned locations
  logic [31:0] mem_seed = 32'h1234_5678;
  logic [21:0] ov_addr [4];
  logic [7:0]  ov_data [4];
  bit          ov_en   [4];

  function automatic logic [7:0] mem_byte(input logic [21:0] a);
    logic [31:0] h;
    for (int i = 0; i < 4; i++)
      if (ov_en[i] && ov_addr[i] == a) return ov_data[i];
    h = ({10'd0, a} * 32'h9E37_79B1) ^ mem_seed;
    return h[31:24] ^ h[15:8];
  endfunction

  // bus monitor: ACC start addresses, ACC lengths, WAIT-low cycles
  logic [21:0] acc_q [$];
  int          acc_len_q [$];
  int          wait_low_cnt = 0;
  int          run = 0;
  bit          gnt_prev = 1'b0;

  always @(negedge mck) begin
    if (disp_gnt && !gnt_prev) acc_q.push_back(disp_ma);
    if (disp_gnt) run++;
    else if (gnt_prev) begin
      acc_len_q.push_back(run);
      run = 0;
    end
    if (!cpu_wait_n) wait_low_cnt++;
    gnt_prev = disp_gnt;
    mem_di = mem_byte(disp_ma);
  end

  logic [21:0] exp_addr [$];
  logic [17:0] exp_cell [$];

  // expected read sequence and cells for one frame from the current registers
  task automatic build_expect();
    int lo, hi, code, fa, base, pl, row;
    logic [7:0] lo_b, hi_b, f_b;
    exp_addr.delete();
    exp_cell.delete();
    for (int ln = 0; ln < LINES; ln++) begin
      for (int c = 0; c < COLS; c++) begin
        row  = ln / 8;
        pl   = ln % 8;
        base = int'(sbr) * 2048 + row * 256 + c * 2;
        lo_b = mem_byte(22'(base));
        hi_b = mem_byte(22'(base + 1));
        lo   = int'(lo_b);
        hi   = int'(hi_b);
        if ((hi / 32) % 2 == 1) begin
          code = (hi % 4) * 256 + lo;
          fa = (code >= 768) ? int'(pb3) * 2048 + (code % 256) * 8 + pl
                             : int'(pb2) * 8192 + code * 8 + pl;
        end else begin
          code = (hi % 2) * 256 + lo;
          fa = (code >= 448) ? int'(pb0) * 512 + (code % 64) * 8 + pl
                             : int'(pb1) * 4096 + code * 8 + pl;
        end
        f_b = mem_byte(22'(fa));
        exp_addr.push_back(22'(base));
        exp_addr.push_back(22'(base + 1));
        exp_addr.push_back(22'(fa));
        exp_cell.push_back({(c == 0 && ln == 0), (c == 0), hi_b, f_b});
      end
    end
  endtask

  task automatic cyc();
    @(negedge mck);
    #1;
  endtask

  task automatic clear_ov();
    for (int i = 0; i < 4; i++) ov_en[i] = 1'b0;
  endtask

  task automatic start_frame();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic abort_frame();
    lcd_on  = 1'b0;
    cpu_req = 1'b0;
    for (int i = 0; i < 50 && busy; i++) cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle busy=%b required 0", busy);
    end
    lcd_on = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rin_n = 1'b0; lcd_on = 1'b0; frame_tick = 1'b0; cpu_req = 1'b0; pix_ready = 1'b0;
    pb0 = '0; pb1 = '0; pb2 = '0; pb3 = '0; sbr = '0;
    clear_ov();
    repeat (3) cyc();
    for (int pass = 0; pass < 2; pass++) begin
      checks++;
      if ({cpu_wait_n, disp_roe_n} !== 2'b11) begin
        errors++;
        $display("FAIL reset_wait_roe wait_n,roe_n=%b required 11", {cpu_wait_n, disp_roe_n});
      end
      checks++;
      if ({disp_gnt, busy, disp_ma} !== 24'd0) begin
        errors++;
        $display("FAIL reset_bus gnt=%b busy=%b ma=%h required 0", disp_gnt, busy, disp_ma);
      end
      checks++;
      if ({pix_valid, pix_sof, pix_sol, pix_attr, pix_font} !== 19'd0) begin
        errors++;
        $display("FAIL reset_pix valid=%b sof=%b sol=%b attr=%h font=%h required 0",
                 pix_valid, pix_sof, pix_sol, pix_attr, pix_font);
      end
      rin_n = 1'b1;
      cyc();
    end
    lcd_on = 1'b1;
    cyc();
  endtask

  task automatic test_first_cell_stall();
    int a0, l0, w0;
    logic [7:0] f;
    f = 8'($urandom);
    sbr = 11'h7E0; pb1 = 10'h3C0;
    pb0 = 13'($urandom); pb2 = 9'($urandom); pb3 = 11'($urandom);
    ov_addr[0] = 22'h3F0000; ov_data[0] = 8'h41; ov_en[0] = 1'b1;
    ov_addr[1] = 22'h3F0001; ov_data[1] = 8'h00; ov_en[1] = 1'b1;
    ov_addr[2] = 22'h3C0208; ov_data[2] = f;     ov_en[2] = 1'b1;
    build_expect();
    pix_ready = 1'b0; cpu_req = 1'b0;
    a0 = acc_q.size(); l0 = acc_len_q.size(); w0 = wait_low_cnt;
    start_frame();
    repeat (150) cyc();
    checks++;
    if (acc_q.size() - a0 != 6) begin
      errors++;
      $display("FAIL stall_reads got %0d required 6", acc_q.size() - a0);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (acc_q[a0 + i] !== exp_addr[i]) begin
          errors++;
          $display("FAIL first_addr[%0d] got %h required %h", i, acc_q[a0 + i], exp_addr[i]);
        end
      end
      checks++;
      if (acc_q[a0 + 2] !== 22'h3C0208) begin
        errors++;
        $display("FAIL first_font_addr got %h required 3c0208", acc_q[a0 + 2]);
      end
    end
    for (int i = l0; i < acc_len_q.size(); i++) begin
      checks++;
      if (acc_len_q[i] != MEM_LAT) begin
        errors++;
        $display("FAIL acc_len got %0d required %0d", acc_len_q[i], MEM_LAT);
      end
    end
    checks++;
    if ({busy, disp_gnt, pix_valid} !== 3'b101) begin
      errors++;
      $display("FAIL stall_park busy,gnt,valid=%b required 101", {busy, disp_gnt, pix_valid});
    end
    checks++;
    if (wait_low_cnt != w0) begin
      errors++;
      $display("FAIL first_wait_n low cycles=%0d required 0", wait_low_cnt - w0);
    end
    checks++;
    if ({pix_sof, pix_sol, pix_attr, pix_font} !== {1'b1, 1'b1, 8'h00, f}) begin
      errors++;
      $display("FAIL first_head got %h required %h", {pix_sof, pix_sol, pix_attr, pix_font},
               {1'b1, 1'b1, 8'h00, f});
    end
    pix_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({pix_valid, pix_sof, pix_sol, pix_attr, pix_font} !== {1'b1, exp_cell[k]}) begin
        errors++;
        $display("FAIL stall_pop[%0d] got %h required %h", k,
                 {pix_valid, pix_sof, pix_sol, pix_attr, pix_font}, {1'b1, exp_cell[k]});
      end
      cyc();
    end
    pix_ready = 1'b0;
    abort_frame();
    clear_ov();
  endtask

  task automatic test_font_addr();
    logic [7:0]  t_hi  [3];
    logic [7:0]  t_lo  [3];
    logic [21:0] t_exp [3];
    int a0;
    t_hi  = '{8'h23, 8'h01, 8'h22};
    t_lo  = '{8'h10, 8'hC5, 8'hFF};
    t_exp = '{22'h3FF880, 22'h357828, 22'h2AB7F8};
    for (int t = 0; t < 3; t++) begin
      sbr = 11'($urandom);
      pb0 = 13'h1ABC; pb1 = 10'($urandom); pb2 = 9'h155; pb3 = 11'h7FF;
      ov_addr[0] = {sbr, 11'd0}; ov_data[0] = t_lo[t]; ov_en[0] = 1'b1;
      ov_addr[1] = {sbr, 11'd1}; ov_data[1] = t_hi[t]; ov_en[1] = 1'b1;
      pix_ready = 1'b1; cpu_req = 1'b0;
      a0 = acc_q.size();
      start_frame();
      for (int i = 0; i < 40 && acc_q.size() < a0 + 3; i++) cyc();
      checks++;
      if (acc_q.size() < a0 + 3) begin
        errors++;
        $display("FAIL font_addr[%0d] timeout reads=%0d required 3", t, acc_q.size() - a0);
      end else if (acc_q[a0 + 2] !== t_exp[t]) begin
        errors++;
        $display("FAIL font_addr[%0d] got %h required %h", t, acc_q[a0 + 2], t_exp[t]);
      end
      abort_frame();
      clear_ov();
    end
  endtask

  task automatic test_starve();
    int n, m, w0;
    bit g;
    pix_ready = 1'b1;
    cpu_req = 1'b1;
    start_frame();
    for (int s = 0; s < 2; s++) begin
      n = 0;
      while (!disp_gnt && n < 40) begin
        n++;
        cyc();
      end
      checks++;
      if (n < STARVE_MAX || n > STARVE_MAX + 1) begin
        errors++;
        $display("FAIL starve_yield[%0d] cycles=%0d required %0d..%0d", s, n, STARVE_MAX, STARVE_MAX + 1);
      end
      m = 0;
      while (disp_gnt && !cpu_wait_n && m < 10) begin
        m++;
        cyc();
      end
      checks++;
      if (m != MEM_LAT) begin
        errors++;
        $display("FAIL starve_wait_len[%0d] got %0d required %0d", s, m, MEM_LAT);
      end
      checks++;
      if ({disp_gnt, cpu_wait_n} !== 2'b01) begin
        errors++;
        $display("FAIL starve_release[%0d] gnt,wait_n=%b required 01", s, {disp_gnt, cpu_wait_n});
      end
    end
    abort_frame();
    // short CPU burst: CPU keeps the bus, display gets it once the request drops
    w0 = wait_low_cnt;
    g = 1'b0;
    cpu_req = 1'b1;
    start_frame();
    repeat (3) begin
      g |= disp_gnt;
      cyc();
    end
    cpu_req = 1'b0;
    for (int i = 0; i < 5 && !disp_gnt; i++) cyc();
    checks++;
    if ({g, disp_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL tie_cpu_wins gnt_during_req=%b gnt_after=%b required 0,1", g, disp_gnt);
    end
    repeat (20) cyc();
    checks++;
    if (wait_low_cnt != w0) begin
      errors++;
      $display("FAIL tie_wait_n low cycles=%0d required 0", wait_low_cnt - w0);
    end
    abort_frame();
  endtask

  task automatic test_full_frame();
    int a0, l0, pops, sol_cnt, sof_cnt, total, pops_at_fall;
    bit done, fell;
    mem_seed = $urandom;
    sbr = 11'($urandom); pb0 = 13'($urandom); pb1 = 10'($urandom);
    pb2 = 9'($urandom);  pb3 = 11'($urandom);
    build_expect();
    total = COLS * LINES;
    pops = 0; sol_cnt = 0; sof_cnt = 0; done = 1'b0; fell = 1'b0; pops_at_fall = 0;
    a0 = acc_q.size(); l0 = acc_len_q.size();
    start_frame();
    for (int c = 0; c < 60000; c++) begin
      pix_ready  = ($urandom % 4) != 0;
      cpu_req    = ($urandom % 4) == 0;
      frame_tick = (c == 100);
      if (c == 100) begin
        sbr = 11'($urandom); pb0 = 13'($urandom); pb1 = 10'($urandom);
        pb2 = 9'($urandom);  pb3 = 11'($urandom);
      end
      if (!busy && !fell) begin
        fell = 1'b1;
        pops_at_fall = pops;
        checks++;
        if (total - pops_at_fall > 2 || acc_q.size() - a0 != 3 * total) begin
          errors++;
          $display("FAIL busy_fall pops=%0d reads=%0d required >=%0d and %0d",
                   pops_at_fall, acc_q.size() - a0, total - 2, 3 * total);
        end
      end
      if (pix_valid && pix_ready) begin
        checks++;
        if (pops >= total || {pix_sof, pix_sol, pix_attr, pix_font} !== exp_cell[pops]) begin
          errors++;
          $display("FAIL cell[%0d] got %h required %h", pops,
                   {pix_sof, pix_sol, pix_attr, pix_font}, (pops < total) ? exp_cell[pops] : 18'h0);
        end
        sol_cnt += int'(pix_sol);
        sof_cnt += int'(pix_sof);
        pops++;
      end
      if (!busy && !pix_valid) begin
        done = 1'b1;
        break;
      end
      cyc();
    end
    frame_tick = 1'b0;
    cpu_req = 1'b0;
    checks++;
    if (!done || pops != total) begin
      errors++;
      $display("FAIL frame_pops done=%b got %0d required %0d", done, pops, total);
    end
    checks++;
    if (sol_cnt != LINES || sof_cnt != 1) begin
      errors++;
      $display("FAIL frame_markers sol=%0d sof=%0d required %0d and 1", sol_cnt, sof_cnt, LINES);
    end
    for (int i = 0; i < 3 * total && a0 + i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[a0 + i] !== exp_addr[i]) begin
        errors++;
        $display("FAIL frame_addr[%0d] got %h required %h", i, acc_q[a0 + i], exp_addr[i]);
      end
    end
    for (int i = l0; i < acc_len_q.size(); i++) begin
      checks++;
      if (acc_len_q[i] != MEM_LAT) begin
        errors++;
        $display("FAIL frame_acc_len got %0d required %0d", acc_len_q[i], MEM_LAT);
      end
    end
    mem_seed = 32'h1234_5678;
  endtask

  task automatic test_lcd_off();
    int a0, l0;
    build_expect();
    pix_ready = 1'b0; cpu_req = 1'b0;
    a0 = acc_q.size(); l0 = acc_len_q.size();
    start_frame();
    for (int i = 0; i < 100 && acc_q.size() < a0 + 5; i++) cyc();
    checks++;
    if ({disp_gnt, pix_valid} !== 2'b11 || acc_q.size() != a0 + 5) begin
      errors++;
      $display("FAIL lcdoff_setup gnt,valid=%b reads=%0d required 11 and 5",
               {disp_gnt, pix_valid}, acc_q.size() - a0);
    end
    lcd_on = 1'b0;
    for (int i = 0; i < 20 && busy; i++) cyc();
    repeat (3) cyc();
    checks++;
    if ({busy, pix_valid, disp_gnt} !== 3'b000) begin
      errors++;
      $display("FAIL lcdoff_idle busy,valid,gnt=%b required 000", {busy, pix_valid, disp_gnt});
    end
    checks++;
    if (acc_q.size() != a0 + 5 || acc_len_q.size() != l0 + 5 || acc_len_q[acc_len_q.size() - 1] != MEM_LAT) begin
      errors++;
      $display("FAIL lcdoff_acc_complete reads=%0d last_len=%0d required 5 and %0d",
               acc_q.size() - a0, (acc_len_q.size() > 0) ? acc_len_q[acc_len_q.size() - 1] : -1, MEM_LAT);
    end
    lcd_on = 1'b1;
    cyc();
  endtask

  task automatic test_reset_mid_acc();
    pix_ready = 1'b1;
    cpu_req = 1'b1;
    start_frame();
    for (int i = 0; i < 30 && !disp_gnt; i++) cyc();
    checks++;
    if ({disp_gnt, cpu_wait_n, disp_roe_n} !== 3'b100) begin
      errors++;
      $display("FAIL rst_setup gnt,wait_n,roe_n=%b required 100", {disp_gnt, cpu_wait_n, disp_roe_n});
    end
    rin_n = 1'b0;
    #1;
    checks++;
    if ({disp_gnt, cpu_wait_n, disp_roe_n, busy, pix_valid} !== 5'b01100 || disp_ma !== 22'd0) begin
      errors++;
      $display("FAIL rst_mid_acc gnt,wait_n,roe_n,busy,valid=%b ma=%h required 01100 and 0",
               {disp_gnt, cpu_wait_n, disp_roe_n, busy, pix_valid}, disp_ma);
    end
    cyc();
    cpu_req = 1'b0;
    rin_n = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_first_cell_stall();
    test_font_addr();
    test_starve();
    test_full_frame();
    test_lcd_off();
    test_reset_mid_acc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
